mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, optional saturation, enable prescaler, synchronous clear and parallel load. It also provides a terminal-count flag, registered overflow/underflow pulses and a compare-match output. It is the general-purpose counter for timers, dividers and event counting, and replaces the fixed free-running binary counters in new designs.

---
 rtl/mod_updown_counter.sv | 95 +++++++++
 tb/tb_mod_updown_counter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_updown_counter
//  Purpose  : Up/down counter with programmable modulus, optional saturation,
//             enable prescaler, clear/load, limit pulses and compare match.
//  Revision : 1.0
// ============================================================================
module mod_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             match
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load) begin
            count_d = (d > MAX_V) ? MAX_V : d;
            pre_d   = '0;
        end else if (en) begin
            if (pre_q != PRE_LAST) begin
                pre_d = pre_q + 1'b1;
            end else begin
                pre_d = '0;
                if (up) begin
                    if (count_q != MAX_V) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = SATURATE ? count_q : '0;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        count_d = SATURATE ? count_q : MAX_V;
                        unf_d   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pre_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Flags are decoded from the registered count; q can never exceed MAX.
    assign q     = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = (up && (count_q == MAX_V)) || (!up && (count_q == '0));
    assign match = (count_q == cmp);

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_updown_counter
//  Purpose  : Directed self-checking bench for wrap, saturate and prescale
//             variants of mod_updown_counter.
//  Revision : 1.0
// ============================================================================
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, load, up;
    logic [3:0] d, cmp;

    logic [3:0] q_w, q_s, q_p;
    logic       tc_w, tc_s, tc_p;
    logic       ovf_w, ovf_s, ovf_p;
    logic       unf_w, unf_s, unf_p;
    logic       m_w, m_s, m_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d), .up(up),
        .cmp(cmp), .q(q_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w), .match(m_w));

    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d), .up(up),
        .cmp(cmp), .q(q_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s), .match(m_s));

    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d), .up(up),
        .cmp(cmp), .q(q_p), .tc(tc_p), .ovf(ovf_p), .unf(unf_p), .match(m_p));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; d = '0; up = 1'b1; cmp = '0;
        #3;
        checks++;
        if ({q_w, q_s, q_p} !== 12'h000) begin
            failures++; $display("FAIL reset_q got w=%0d s=%0d p=%0d want 0", q_w, q_s, q_p);
        end
        checks++;
        if ({ovf_w, unf_w, ovf_s, unf_s, ovf_p, unf_p} !== 6'b0) begin
            failures++; $display("FAIL reset_pulses got %b want 000000",
                                 {ovf_w, unf_w, ovf_s, unf_s, ovf_p, unf_p});
        end
        checks++;
        if ({tc_w, m_w} !== 2'b01) begin
            failures++; $display("FAIL reset_tc_match_up got tc=%b match=%b want tc=0 match=1", tc_w, m_w);
        end
        up = 1'b0;
        #1;
        checks++;
        if (tc_w !== 1'b1) begin
            failures++; $display("FAIL reset_tc_down got %b want 1", tc_w);
        end
    endtask

    task automatic test_free_run_up();
        logic [3:0] exp_q;
        tick();
        rst = 1'b1; up = 1'b1; en = 1'b1; cmp = 4'd5;
        exp_q = 4'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_q = (exp_q == 4'd9) ? 4'd0 : exp_q + 4'd1;
            checks++;
            if (q_w !== exp_q || tc_w !== (exp_q == 4'd9) || ovf_w !== (i == 9) ||
                m_w !== (exp_q == 4'd5)) begin
                failures++;
                $display("FAIL free_run[%0d] got q=%0d tc=%b ovf=%b match=%b want q=%0d tc=%b ovf=%b match=%b",
                         i, q_w, tc_w, ovf_w, m_w, exp_q, exp_q == 4'd9, i == 9, exp_q == 4'd5);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_q [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
        logic       exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        up = 1'b1; en = 1'b1; load = 1'b1; d = 4'd8;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0;
            checks++;
            if (q_s !== exp_q[i] || ovf_s !== exp_o[i] || unf_s !== 1'b0) begin
                failures++;
                $display("FAIL sat_up[%0d] got q=%0d ovf=%b unf=%b want q=%0d ovf=%b unf=0",
                         i, q_s, ovf_s, unf_s, exp_q[i], exp_o[i]);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0; up = 1'b0;
        checks++;
        if (q_s !== 4'd0 || ovf_s !== 1'b0) begin
            failures++; $display("FAIL sat_clr got q=%0d ovf=%b want q=0 ovf=0", q_s, ovf_s);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q_s !== 4'd0 || unf_s !== 1'b1 || ovf_s !== 1'b0) begin
                failures++;
                $display("FAIL sat_down[%0d] got q=%0d unf=%b ovf=%b want q=0 unf=1 ovf=0",
                         i, q_s, unf_s, ovf_s);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (q_s !== 4'd0 || unf_s !== 1'b0) begin
            failures++; $display("FAIL sat_idle got q=%0d unf=%b want q=0 unf=0", q_s, unf_s);
        end
    endtask

    task automatic test_down_wrap_dir();
        load = 1'b1; d = 4'd1; en = 1'b0;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (q_w !== 4'd0 || unf_w !== 1'b0 || tc_w !== 1'b1) begin
            failures++; $display("FAIL down_1to0 got q=%0d unf=%b tc=%b want q=0 unf=0 tc=1", q_w, unf_w, tc_w);
        end
        en = 1'b0; up = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            failures++; $display("FAIL dir_tc_drop got %b want 0", tc_w);
        end
        up = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (q_w !== 4'd9 || unf_w !== 1'b1 || tc_w !== 1'b0) begin
            failures++; $display("FAIL down_wrap got q=%0d unf=%b tc=%b want q=9 unf=1 tc=0", q_w, unf_w, tc_w);
        end
        en = 1'b0; up = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b1) begin
            failures++; $display("FAIL dir_tc_rise got %b want 1", tc_w);
        end
        en = 1'b1;
        tick();
        checks++;
        if (q_w !== 4'd0 || ovf_w !== 1'b1 || unf_w !== 1'b0) begin
            failures++; $display("FAIL dir_up_wrap got q=%0d ovf=%b unf=%b want q=0 ovf=1 unf=0", q_w, ovf_w, unf_w);
        end
    endtask

    task automatic test_prescaler();
        logic       en_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_q  [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
        en = 1'b0; clr = 1'b1; up = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = en_pat[i];
            tick();
            checks++;
            if (q_p !== exp_q[i]) begin
                failures++; $display("FAIL pre_seq[%0d] got q=%0d want %0d", i, q_p, exp_q[i]);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (q_p !== 4'd2) begin
            failures++; $display("FAIL pre_seq_step2 got q=%0d want 2", q_p);
        end
        tick();
        load = 1'b1; d = 4'd5;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q_p !== ((i == 2) ? 4'd6 : 4'd5)) begin
                failures++; $display("FAIL pre_after_load[%0d] got q=%0d want %0d", i, q_p, (i == 2) ? 6 : 5);
            end
        end
    endtask

    task automatic test_priority();
        up = 1'b1; en = 1'b1; clr = 1'b1; load = 1'b1; d = 4'd5;
        tick();
        checks++;
        if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
            failures++; $display("FAIL clr_over_load got q=%0d ovf=%b want q=0 ovf=0", q_w, ovf_w);
        end
        clr = 1'b0; d = 4'd15;
        tick();
        checks++;
        if (q_w !== 4'd9 || q_s !== 4'd9 || q_p !== 4'd9) begin
            failures++; $display("FAIL load_clamp got w=%0d s=%0d p=%0d want 9", q_w, q_s, q_p);
        end
        d = 4'd9;
        tick();
        checks++;
        if (q_w !== 4'd9 || ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
            failures++; $display("FAIL load_at_limit got q=%0d ovf_w=%b ovf_s=%b want q=9 ovf=0",
                                 q_w, ovf_w, ovf_s);
        end
        load = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        checks++;
        if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
            failures++; $display("FAIL clr_at_limit got q=%0d ovf=%b want q=0 ovf=0", q_w, ovf_w);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; d = 4'd7; en = 1'b0; up = 1'b1; cmp = 4'd7;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (q_p !== 4'd7 || m_p !== 1'b1) begin
            failures++; $display("FAIL pre_reset_state got q=%0d match=%b want q=7 match=1", q_p, m_p);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (q_p !== 4'd0 || q_w !== 4'd0 || ovf_p !== 1'b0 || unf_p !== 1'b0 || m_p !== 1'b0) begin
            failures++; $display("FAIL async_reset got q=%0d/%0d ovf=%b unf=%b match=%b want 0/0 0 0 0",
                                 q_p, q_w, ovf_p, unf_p, m_p);
        end
        cmp = 4'd0;
        #1;
        checks++;
        if (m_p !== 1'b1) begin
            failures++; $display("FAIL async_reset_match0 got %b want 1", m_p);
        end
        tick();
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q_p !== ((i == 2) ? 4'd1 : 4'd0)) begin
                failures++; $display("FAIL post_reset_pre[%0d] got q=%0d want %0d", i, q_p, (i == 2) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run_up();
        test_saturation();
        test_down_wrap_dir();
        test_prescaler();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
